// File: rtl/nav_pkg.sv
// rtl/nav_pkg.sv - shared motion codes, FSM states and coordinate limit for the nav tracker
//
// Purpose: constants and types used by nav_packet_tracker and its helpers.
// Ports:   none (package).

package nav_pkg;

  localparam logic [2:0] MOT_STOP  = 3'd0;
  localparam logic [2:0] MOT_FWD   = 3'd1;
  localparam logic [2:0] MOT_BACK  = 3'd2;
  localparam logic [2:0] MOT_LEFT  = 3'd3;
  localparam logic [2:0] MOT_RIGHT = 3'd4;

  localparam logic [15:0] MAX_COORD_DEFAULT = 16'd12000;

  typedef enum logic [1:0] {
    ST_NO_LINK = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } nav_state_e;

  // The whole raw byte is checked, so codes like 8'h81 are rejected too.
  function automatic logic motion_is_valid(input logic [7:0] raw);
    return raw <= {5'd0, MOT_RIGHT};
  endfunction

endpackage

// File: rtl/nav_watchdog.sv
// rtl/nav_watchdog.sv - link-loss watchdog counter with clear and timeout pulse
//
// Purpose: counts cycles since the last clear and pulses timeout_o when the
//          count reaches TIMEOUT_CYCLES-1.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   clear_i    in   restart the count (an accepted packet); suppresses timeout
//   timeout_o  out  one-cycle timeout pulse

module nav_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);

  // A clear in the expiry cycle wins, so a packet arriving exactly on time
  // keeps the link alive.
  assign timeout_o = at_last && !clear_i;

  // Restart after expiry so a dead link keeps timing out once per period.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || at_last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nav_packet_tracker.sv
// rtl/nav_packet_tracker.sv - validates nav packets, tracks link state and confirms motion commands
//
// Purpose: accepts/rejects incoming lidar+motion packets, holds the last good
//          coordinates, runs a NO_LINK/ACQUIRE/LOCKED link FSM with a watchdog,
//          and publishes a two-packet-confirmed motion command while locked.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   packet_valid                    one-cycle packet strobe
//   motion_state                    raw motion byte
//   lidar_{x,y}_{upper,lower}       raw coordinate bytes
//   lidar_x, lidar_y                last accepted coordinates
//   motion_cmd                      confirmed motion code (STOP outside lock)
//   cmd_valid                       one-cycle strobe after an accepted packet while locking/locked
//   link_ok                         high in LOCKED
//   packet_count                    accepted packets (wraps)
//   error_count                     rejected packets (saturates)

module nav_packet_tracker
  import nav_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned ACQ_PACKETS    = 3,
  parameter logic [15:0] MAX_COORD      = MAX_COORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        packet_valid,
  input  logic [7:0]  motion_state,
  input  logic [7:0]  lidar_x_upper,
  input  logic [7:0]  lidar_x_lower,
  input  logic [7:0]  lidar_y_upper,
  input  logic [7:0]  lidar_y_lower,
  output logic [15:0] lidar_x,
  output logic [15:0] lidar_y,
  output logic [2:0]  motion_cmd,
  output logic        cmd_valid,
  output logic        link_ok,
  output logic [15:0] packet_count,
  output logic [7:0]  error_count
);

  localparam logic [15:0] ACQ_TARGET = 16'(ACQ_PACKETS);

  logic [15:0] coord_x, coord_y;
  logic [2:0]  motion_code;
  logic        fields_ok, accept, reject, timeout;

  nav_state_e  state_q, state_d;
  logic [15:0] acq_q, acq_d, acq_inc;

  logic [15:0] x_q, x_d, y_q, y_d;
  logic [2:0]  prev_motion_q, prev_motion_d;
  logic [2:0]  motion_cmd_q, motion_cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        locked_next;

  assign coord_x     = {lidar_x_upper, lidar_x_lower};
  assign coord_y     = {lidar_y_upper, lidar_y_lower};
  assign motion_code = motion_state[2:0];
  assign fields_ok   = motion_is_valid(motion_state) && (coord_x <= MAX_COORD) && (coord_y <= MAX_COORD);
  assign accept      = packet_valid && fields_ok;
  assign reject      = packet_valid && !fields_ok;
  assign acq_inc     = acq_q + 16'd1;

  nav_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .timeout_o(timeout)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NO_LINK;
      acq_q   <= '0;
    end else begin
      state_q <= state_d;
      acq_q   <= acq_d;
    end
  end

  // FSM next state; timeout is already masked by an accepted packet
  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    case (state_q)
      ST_NO_LINK: begin
        if (accept) begin
          acq_d   = 16'd1;
          state_d = (16'd1 >= ACQ_TARGET) ? ST_LOCKED : ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        if (accept) begin
          acq_d = acq_inc;
          if (acq_inc >= ACQ_TARGET) begin
            state_d = ST_LOCKED;
          end
        end else if (timeout) begin
          state_d = ST_NO_LINK;
          acq_d   = '0;
        end else if (reject) begin
          acq_d = '0;
        end
      end
      ST_LOCKED: begin
        if (timeout) begin
          state_d = ST_NO_LINK;
          acq_d   = '0;
        end
      end
      default: begin
        state_d = ST_NO_LINK;
        acq_d   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    link_ok      = (state_q == ST_LOCKED);
    locked_next  = (state_d == ST_LOCKED);
    cmd_valid_d  = accept && locked_next;
    motion_cmd_d = motion_cmd_q;
    if (!locked_next) begin
      // Covers the timeout cycle as well as NO_LINK/ACQUIRE.
      motion_cmd_d = MOT_STOP;
    end else if (accept && (motion_code == prev_motion_q)) begin
      motion_cmd_d = motion_code;
    end
  end

  // Packet datapath next state
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    prev_motion_d = prev_motion_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_cnt_d     = err_cnt_q;
    if (accept) begin
      x_d           = coord_x;
      y_d           = coord_y;
      prev_motion_d = motion_code;
      pkt_cnt_d     = pkt_cnt_q + 16'd1;
    end
    if (reject && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      prev_motion_q <= MOT_STOP;
      motion_cmd_q  <= MOT_STOP;
      cmd_valid_q   <= 1'b0;
      pkt_cnt_q     <= '0;
      err_cnt_q     <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      prev_motion_q <= prev_motion_d;
      motion_cmd_q  <= motion_cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      pkt_cnt_q     <= pkt_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign lidar_x      = x_q;
  assign lidar_y      = y_q;
  assign motion_cmd   = motion_cmd_q;
  assign cmd_valid    = cmd_valid_q;
  assign packet_count = pkt_cnt_q;
  assign error_count  = err_cnt_q;

endmodule

// File: tb/tb_nav_packet_tracker.sv
// tb/tb_nav_packet_tracker.sv - directed scoreboard bench for nav_packet_tracker

module tb_nav_packet_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        packet_valid;
  logic [7:0]  motion_state;
  logic [7:0]  lidar_x_upper, lidar_x_lower, lidar_y_upper, lidar_y_lower;
  logic [15:0] lidar_x, lidar_y;
  logic [2:0]  motion_cmd;
  logic        cmd_valid;
  logic        link_ok;
  logic [15:0] packet_count;
  logic [7:0]  error_count;

  always #5 clk = ~clk;

  nav_packet_tracker #(
    .TIMEOUT_CYCLES(100),
    .ACQ_PACKETS   (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .packet_valid (packet_valid),
    .motion_state (motion_state),
    .lidar_x_upper(lidar_x_upper),
    .lidar_x_lower(lidar_x_lower),
    .lidar_y_upper(lidar_y_upper),
    .lidar_y_lower(lidar_y_lower),
    .lidar_x      (lidar_x),
    .lidar_y      (lidar_y),
    .motion_cmd   (motion_cmd),
    .cmd_valid    (cmd_valid),
    .link_ok      (link_ok),
    .packet_count (packet_count),
    .error_count  (error_count)
  );

  typedef struct {
    string       tag;
    logic        link;
    logic        cv;
    logic [2:0]  mc;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] pc;
    logic [7:0]  ec;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic        e_link, e_cv;
  logic [2:0]  e_mc;
  logic [15:0] e_x, e_y, e_pc;
  logic [7:0]  e_ec;

  task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] m, input logic [15:0] x, input logic [15:0] y);
    packet_valid  = 1'b1;
    motion_state  = m;
    lidar_x_upper = x[15:8];
    lidar_x_lower = x[7:0];
    lidar_y_upper = y[15:8];
    lidar_y_lower = y[7:0];
  endtask

  task automatic idle();
    packet_valid  = 1'b0;
    motion_state  = 8'd0;
    lidar_x_upper = 8'd0;
    lidar_x_lower = 8'd0;
    lidar_y_upper = 8'd0;
    lidar_y_lower = 8'd0;
  endtask

  // Push the expectation for this cycle, clock, then pop and compare.
  task automatic cyc(input string tag);
    exp_t e;
    e.tag = tag; e.link = e_link; e.cv = e_cv; e.mc = e_mc;
    e.x = e_x; e.y = e_y; e.pc = e_pc; e.ec = e_ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "link_ok",      {15'd0, link_ok},     {15'd0, e.link});
    chk(e.tag, "cmd_valid",    {15'd0, cmd_valid},   {15'd0, e.cv});
    chk(e.tag, "motion_cmd",   {13'd0, motion_cmd},  {13'd0, e.mc});
    chk(e.tag, "lidar_x",      lidar_x,              e.x);
    chk(e.tag, "lidar_y",      lidar_y,              e.y);
    chk(e.tag, "packet_count", packet_count,         e.pc);
    chk(e.tag, "error_count",  {8'd0, error_count},  {8'd0, e.ec});
    rst = 1'b0;
    idle();
  endtask

  task automatic exp_reset();
    e_link = 1'b0; e_cv = 1'b0; e_mc = 3'd0;
    e_x = 16'd0; e_y = 16'd0; e_pc = 16'd0; e_ec = 8'd0;
  endtask

  initial begin
    idle();
    exp_reset();

    rst = 1'b1; cyc("reset0");
    rst = 1'b1; cyc("reset1");

    // three good packets lock the link on the third
    for (int i = 1; i <= 3; i++) begin
      drive(8'd1, 16'h0100, 16'h0200);
      e_x = 16'd256; e_y = 16'd512; e_pc = 16'(i);
      e_link = (i == 3); e_cv = (i == 3); e_mc = (i == 3) ? 3'd1 : 3'd0;
      cyc("acq_lock");
    end
    e_cv = 1'b0; cyc("post_lock_idle");

    // two-packet confirmation while locked; second packet sits on the coordinate limit
    drive(8'd2, 16'h0300, 16'h0400);
    e_x = 16'h0300; e_y = 16'h0400; e_pc = 16'd4; e_cv = 1'b1; e_mc = 3'd1;
    cyc("confirm_first");
    drive(8'd2, 16'd12000, 16'd12000);
    e_x = 16'd12000; e_y = 16'd12000; e_pc = 16'd5; e_mc = 3'd2;
    cyc("confirm_second");

    // rejections while locked
    drive(8'd1, 16'h2EE1, 16'd5); e_cv = 1'b0; e_ec = 8'd1; cyc("rej_x");
    drive(8'd7, 16'd5, 16'd5);    e_ec = 8'd2; cyc("rej_motion");
    drive(8'd1, 16'd5, 16'h2EE1); e_ec = 8'd3; cyc("rej_y");

    // 99 cycles since the last accept, then a good packet in the expiry cycle
    for (int i = 0; i < 96; i++) cyc("wd_run");
    drive(8'd2, 16'h0010, 16'h0020);
    e_x = 16'h0010; e_y = 16'h0020; e_pc = 16'd6; e_cv = 1'b1;
    cyc("accept_at_expiry");

    // silence: link drops on the 100th idle cycle
    e_cv = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 100) begin
        e_link = 1'b0; e_mc = 3'd0;
      end
      cyc("timeout");
    end

    // reacquire with a rejection that restarts the acquire count
    drive(8'd3, 16'h0AAA, 16'h0BBB); e_x = 16'h0AAA; e_y = 16'h0BBB; e_pc = 16'd7; cyc("reacq1");
    drive(8'd3, 16'h0AAA, 16'h0BBB); e_pc = 16'd8; cyc("reacq2");
    drive(8'd5, 16'h0AAA, 16'h0BBB); e_ec = 8'd4; cyc("acq_reject");
    drive(8'd3, 16'h0CCC, 16'h0DDD); e_x = 16'h0CCC; e_y = 16'h0DDD; e_pc = 16'd9; cyc("restart1");
    drive(8'd3, 16'h0CCC, 16'h0DDD); e_pc = 16'd10; cyc("restart2");
    drive(8'd3, 16'h0CCC, 16'h0DDD); e_pc = 16'd11; e_link = 1'b1; e_cv = 1'b1; e_mc = 3'd3;
    cyc("restart3");

    // reset wins over a coincident good packet while locked
    rst = 1'b1;
    drive(8'd3, 16'h0100, 16'h0100);
    exp_reset();
    cyc("rst_with_pkt");
    cyc("after_rst");

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(8'd6, 16'd0, 16'd0);
      if (e_ec != 8'hFF) e_ec = e_ec + 8'd1;
      cyc("err_sat");
    end
    chk("err_sat_final", "error_count", {8'd0, error_count}, 16'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
